// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared FSM encoding and BCD/hour helpers for chime_ctrl
package clock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PIP_ON,
    PIP_WAIT,
    TOP,
    STRIKE_ON,
    STRIKE_GAP
  } chime_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Two BCD digits to binary; callers check digit validity separately.
  function automatic logic [7:0] bcd_to_bin(input logic [3:0] t, input logic [3:0] u);
    return ({4'd0, t} << 3) + ({4'd0, t} << 1) + {4'd0, u};
  endfunction

  function automatic logic [3:0] to_hour12(input logic [7:0] h);
    if (h == 8'd0)
      return 4'd12;
    else if (h > 8'd12)
      return 4'(h - 8'd12);
    else
      return h[3:0];
  endfunction

endpackage

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - square-wave tone generator, restarts high whenever on rises
module tone_gen #(
  parameter int LO_HALF = 2,
  parameter int HI_HALF = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hi_sel,
  input  logic on,
  output logic wave
);

  localparam int HMAX = (LO_HALF > HI_HALF) ? LO_HALF : HI_HALF;
  localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

  logic [HW-1:0] cnt_q;
  logic          phase_q;
  logic [HW-1:0] last;

  assign last = hi_sel ? HW'(HI_HALF - 1) : HW'(LO_HALF - 1);
  assign wave = on & phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else if (!on) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else if (cnt_q == last) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + HW'(1);
    end
  end

endmodule

// File: rtl/chime_ctrl.sv
// rtl/chime_ctrl.sv - hourly chime controller: pre-hour pips plus top tone, or hour strikes
module chime_ctrl import clock_pkg::*; #(
  parameter int CLK_HZ      = 1000,
  parameter int PIPS        = 4,
  parameter int BEEP_CYC    = 500,
  parameter int TOP_CYC     = 1000,
  parameter int GAP_CYC     = 500,
  parameter int LO_HALF     = 2,
  parameter int HI_HALF     = 1,
  parameter int QUIET_START = 22,
  parameter int QUIET_END   = 7
) (
  input  logic       clk_1k,
  input  logic       cr,
  input  logic [3:0] bcd_su,
  input  logic [3:0] bcd_st,
  input  logic [3:0] bcd_mu,
  input  logic [3:0] bcd_mt,
  input  logic [3:0] bcd_hu,
  input  logic [3:0] bcd_ht,
  input  logic       en,
  input  logic       mode,
  input  logic       quiet_en,
  output logic       radio_alarm,
  output logic       busy,
  output logic [3:0] strikes_left
);

  localparam int          MAX_CYC = max3(BEEP_CYC, TOP_CYC, GAP_CYC);
  localparam int          CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [7:0]  PIP_SS  = 8'(60 - PIPS);
  localparam bit          WRAP    = QUIET_START > QUIET_END;

  // A pip must finish inside its second or the next tick would be missed.
  if (PIPS < 1 || PIPS > 9 || BEEP_CYC >= CLK_HZ) begin : g_bad_params
    $error("chime_ctrl: invalid parameter set");
  end

  chime_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    strikes_q, strikes_d;
  logic [5:0]    pip_sec_q, pip_sec_d;
  logic [3:0]    su_q;
  logic          hist_q;

  logic       tick;
  logic [7:0] ss, mm, hour;
  logic       time_ok, in_quiet, can_start, at_hour, tone_on;

  assign tick    = hist_q && (bcd_su != su_q);
  assign ss      = bcd_to_bin(bcd_st, bcd_su);
  assign mm      = bcd_to_bin(bcd_mt, bcd_mu);
  assign hour    = bcd_to_bin(bcd_ht, bcd_hu);
  assign time_ok = (bcd_su <= 4'd9) && (bcd_st <= 4'd5) && (bcd_mu <= 4'd9) &&
                   (bcd_mt <= 4'd5) && (bcd_hu <= 4'd9) && (bcd_ht <= 4'd2) &&
                   (hour <= 8'd23);
  assign in_quiet = WRAP ? ((hour >= 8'(QUIET_START)) || (hour < 8'(QUIET_END)))
                         : ((hour >= 8'(QUIET_START)) && (hour < 8'(QUIET_END)));
  assign can_start = en && time_ok && !(quiet_en && in_quiet);
  assign at_hour   = (mm == 8'd0) && (ss == 8'd0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    strikes_d = strikes_q;
    pip_sec_d = pip_sec_q;
    if (!en && state_q != IDLE) begin
      state_d   = IDLE;
      cnt_d     = '0;
      strikes_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (tick && can_start) begin
            if (!mode && mm == 8'd59 && ss == PIP_SS) begin
              state_d   = PIP_ON;
              pip_sec_d = ss[5:0];
            end else if (mode && at_hour) begin
              state_d   = STRIKE_ON;
              strikes_d = to_hour12(hour);
            end
          end
        end
        PIP_ON: begin
          if (cnt_q == CW'(BEEP_CYC - 1)) begin
            state_d = PIP_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PIP_WAIT: begin
          if (tick) begin
            if (time_ok && mm == 8'd59 && pip_sec_q < 6'd59 && ss == 8'(pip_sec_q) + 8'd1) begin
              state_d   = PIP_ON;
              pip_sec_d = ss[5:0];
            end else if (time_ok && at_hour) begin
              state_d = TOP;
            end else begin
              state_d = IDLE;
            end
          end
        end
        TOP: begin
          if (cnt_q == CW'(TOP_CYC - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STRIKE_ON: begin
          if (cnt_q == CW'(BEEP_CYC - 1)) begin
            strikes_d = strikes_q - 4'd1;
            state_d   = (strikes_q > 4'd1) ? STRIKE_GAP : IDLE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STRIKE_GAP: begin
          if (cnt_q == CW'(GAP_CYC - 1)) begin
            state_d = STRIKE_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_1k or negedge cr) begin
    if (!cr) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      strikes_q <= '0;
      pip_sec_q <= '0;
      su_q      <= '0;
      hist_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      strikes_q <= strikes_d;
      pip_sec_q <= pip_sec_d;
      su_q      <= bcd_su;
      hist_q    <= 1'b1;
    end
  end

  // Outputs decode straight from state so an async reset silences them at once.
  assign tone_on      = (state_q == PIP_ON) || (state_q == TOP) || (state_q == STRIKE_ON);
  assign busy         = (state_q != IDLE);
  assign strikes_left = strikes_q;

  tone_gen #(
    .LO_HALF (LO_HALF),
    .HI_HALF (HI_HALF)
  ) u_tone (
    .clk    (clk_1k),
    .rst_n  (cr),
    .hi_sel (state_q != PIP_ON),
    .on     (tone_on),
    .wave   (radio_alarm)
  );

endmodule

// File: tb/tb_chime_ctrl.sv
// tb/tb_chime_ctrl.sv - scoreboard bench for chime_ctrl with directed time sequences
module tb_chime_ctrl;

  logic       clk_1k = 1'b0;
  logic       cr     = 1'b0;
  logic [3:0] su, st, mu, mt, hu, ht;
  logic       en, mode, quiet_en;
  logic       radio_alarm, busy;
  logic [3:0] strikes_left;

  chime_ctrl dut (
    .clk_1k       (clk_1k),
    .cr           (cr),
    .bcd_su       (su),
    .bcd_st       (st),
    .bcd_mu       (mu),
    .bcd_mt       (mt),
    .bcd_hu       (hu),
    .bcd_ht       (ht),
    .en           (en),
    .mode         (mode),
    .quiet_en     (quiet_en),
    .radio_alarm  (radio_alarm),
    .busy         (busy),
    .strikes_left (strikes_left)
  );

  always #5 clk_1k = ~clk_1k;

  // One tone burst: length of its first high run, count of high clocks, strikes_left at its start.
  typedef struct {
    int half;
    int highs;
    int sl;
  } seg_t;

  seg_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input int half, input int highs, input int sl);
    seg_t s;
    s.half  = half;
    s.highs = highs;
    s.sl    = sl;
    exp_q.push_back(s);
  endtask

  task automatic push_strikes(input int n);
    for (int k = n; k >= 1; k--) push(1, 250, k);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    ht = 4'(h / 10); hu = 4'(h % 10);
    mt = 4'(m / 10); mu = 4'(m % 10);
    st = 4'(s / 10); su = 4'(s % 10);
  endtask

  // Present a new time at a falling edge and hold it for one 1000-clock second.
  task automatic sec(input int h, input int m, input int s);
    @(negedge clk_1k);
    set_time(h, m, s);
    repeat (999) @(negedge clk_1k);
  endtask

  task automatic watch_idle(input string name, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk_1k);
      if (busy || radio_alarm) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin : monitor
    int   in_seg, first_run, highs, half, zeros, sl0;
    seg_t e;
    in_seg = 0; first_run = 0; highs = 0; half = 0; zeros = 0; sl0 = 0;
    forever begin
      @(negedge clk_1k);
      if (radio_alarm) begin
        if (in_seg == 0) begin
          in_seg = 1; first_run = 1; highs = 0; half = 0; sl0 = int'(strikes_left);
        end
        highs++;
        if (first_run != 0) half++;
        zeros = 0;
      end else if (in_seg != 0) begin
        first_run = 0;
        zeros++;
        if (zeros == 3) begin
          in_seg = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_tone_highs", highs, 0);
          end else begin
            e = exp_q.pop_front();
            check("seg_half_period", half, e.half);
            check("seg_high_clocks", highs, e.highs);
            check("seg_strikes_left", sl0, e.sl);
          end
        end
      end
    end
  end

  initial begin
    en = 1'b1; mode = 1'b0; quiet_en = 1'b0;
    set_time(10, 59, 56);
    repeat (3) @(negedge clk_1k);
    check("reset_radio_alarm", radio_alarm, 0);
    check("reset_busy", busy, 0);
    check("reset_strikes_left", strikes_left, 0);
    cr = 1'b1;
    repeat (5) @(negedge clk_1k);
    check("no_tick_after_reset", busy, 0);

    // Pips at :56-:59 then the top-of-hour tone
    sec(10, 59, 55);
    push(2, 250, 0); sec(10, 59, 56);
    check("pip_wait_busy", busy, 1);
    push(2, 250, 0); sec(10, 59, 57);
    push(2, 250, 0); sec(10, 59, 58);
    push(2, 250, 0); sec(10, 59, 59);
    push(1, 500, 0); sec(11, 0, 0);
    sec(11, 0, 1);
    check("after_top_busy", busy, 0);
    check("after_top_alarm", radio_alarm, 0);

    // Four strikes at 16:00
    mode = 1'b1;
    sec(15, 59, 59);
    push_strikes(4);
    @(negedge clk_1k);
    set_time(16, 0, 0);
    repeat (11) @(negedge clk_1k);
    check("strikes_loaded_16h", strikes_left, 4);
    check("strike_busy", busy, 1);
    repeat (4100) @(negedge clk_1k);
    check("strikes_done_left", strikes_left, 0);
    check("strikes_done_busy", busy, 0);

    // Midnight strikes twelve
    sec(23, 59, 59);
    push_strikes(12);
    sec(0, 0, 0);
    repeat (11500) @(negedge clk_1k);
    check("midnight_done_busy", busy, 0);

    // Mute window in both modes, then 23:00 unmuted
    quiet_en = 1'b1;
    sec(22, 59, 59);
    @(negedge clk_1k);
    set_time(23, 0, 0);
    watch_idle("quiet_strike_idle", 1500);
    mode = 1'b0;
    sec(22, 59, 55);
    @(negedge clk_1k);
    set_time(22, 59, 56);
    watch_idle("quiet_pip_idle", 1500);
    quiet_en = 1'b0;
    mode = 1'b1;
    sec(22, 59, 59);
    push_strikes(11);
    sec(23, 0, 0);
    repeat (10600) @(negedge clk_1k);
    check("eleven_done_busy", busy, 0);

    // Invalid hour digit never starts
    sec(9, 59, 59);
    @(negedge clk_1k);
    ht = 4'd1; hu = 4'hA; mt = 4'd0; mu = 4'd0; st = 4'd0; su = 4'd0;
    watch_idle("invalid_bcd_idle", 1200);

    // Time jump during PIP_WAIT aborts without a top tone
    mode = 1'b0;
    sec(10, 59, 55);
    push(2, 250, 0); sec(10, 59, 56);
    push(2, 250, 0); sec(10, 59, 57);
    @(negedge clk_1k);
    set_time(10, 30, 0);
    repeat (3) @(negedge clk_1k);
    check("abort_busy", busy, 0);
    watch_idle("abort_no_top", 1500);

    // en dropped during the third strike of four
    mode = 1'b1;
    sec(3, 59, 59);
    push(1, 250, 4); push(1, 250, 3); push(1, 51, 2);
    @(negedge clk_1k);
    set_time(4, 0, 0);
    repeat (2101) @(negedge clk_1k);
    check("third_strike_tone", radio_alarm, 1);
    check("third_strike_left", strikes_left, 2);
    #1 en = 1'b0;
    @(negedge clk_1k);
    check("en_drop_alarm", radio_alarm, 0);
    check("en_drop_left", strikes_left, 0);
    check("en_drop_busy", busy, 0);
    en = 1'b1;
    repeat (20) @(negedge clk_1k);

    // Asynchronous reset in the middle of the top tone
    mode = 1'b0;
    sec(10, 59, 55);
    push(2, 250, 0); sec(10, 59, 56);
    push(2, 250, 0); sec(10, 59, 57);
    push(2, 250, 0); sec(10, 59, 58);
    push(2, 250, 0); sec(10, 59, 59);
    push(1, 51, 0);
    @(negedge clk_1k);
    set_time(11, 0, 0);
    repeat (101) @(negedge clk_1k);
    #2 cr = 1'b0;
    #1;
    check("async_reset_alarm", radio_alarm, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_left", strikes_left, 0);
    @(negedge clk_1k);
    cr = 1'b1;
    repeat (5) @(negedge clk_1k);
    check("post_reset_busy", busy, 0);

    repeat (20) @(negedge clk_1k);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
